gshare_predictor: RTL and testbench



---
 rtl/bp_pkg.sv | 31 +++
 rtl/pht_ram.sv | 23 ++
 rtl/gshare_predictor.sv | 112 +++++++++++
 tb/tb_gshare_predictor.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the gshare branch predictor: FSM states and counter helpers.
package bp_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } bp_state_e;

  // Counters are handled at the widest legal width (4) and truncated by the caller.
  function automatic logic [3:0] WEAK_NT(input int unsigned cnt_w);
    return 4'((1 << (cnt_w - 1)) - 1);
  endfunction

  function automatic logic [3:0] CNT_MAX(input int unsigned cnt_w);
    return 4'((1 << cnt_w) - 1);
  endfunction

  // Saturating up/down step of a direction counter.
  function automatic logic [3:0] sat_next(input logic [3:0] cnt, input logic taken,
                                          input int unsigned cnt_w);
    logic [3:0] res;
    res = cnt;
    if (taken) begin
      if (cnt != CNT_MAX(cnt_w)) res = cnt + 4'd1;
    end else begin
      if (cnt != 4'd0) res = cnt - 4'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pht_ram.sv
// Pattern history table storage: one async read port, one sync write port, no reset.
module pht_ram #(
  parameter int unsigned IDX_W = 8,
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [CNT_W-1:0] wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [CNT_W-1:0] rdata
);

  logic [CNT_W-1:0] mem [2**IDX_W];

  // Synchronous write; contents are initialised by the owner's sweep.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/gshare_predictor.sv
// gshare direction predictor: PC xor speculative GHR indexes a table of saturating counters.
module gshare_predictor
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W = 8,
  parameter int unsigned GHR_W = 8,
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PL_stall,
  input  logic             PL_flush,
  input  logic             pred_valid,
  input  logic [31:0]      pred_pc,
  output logic             pred_taken,
  output logic [IDX_W-1:0] pred_idx,
  output logic [GHR_W-1:0] pred_ghr,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic [GHR_W-1:0] upd_ghr,
  input  logic             upd_taken,
  input  logic             upd_mispredict,
  output logic             init_busy
);

  if (GHR_W < 1 || GHR_W > IDX_W) begin : g_bad_ghr_w
    $error("GHR_W must be in 1..IDX_W");
  end
  if (CNT_W < 2 || CNT_W > 4) begin : g_bad_cnt_w
    $error("CNT_W must be in 2..4");
  end

  bp_state_e        state_q, state_d;
  logic [IDX_W-1:0] init_ptr_q, init_ptr_d;
  logic [GHR_W-1:0] ghr_q, ghr_d;

  logic             we;
  logic [IDX_W-1:0] waddr;
  logic [CNT_W-1:0] wdata;
  logic [CNT_W-1:0] pred_cnt;
  logic [CNT_W-1:0] upd_cnt;

  logic unused_pc;
  assign unused_pc = ^{pred_pc[31:IDX_W+2], pred_pc[1:0]};

  assign pred_idx   = pred_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
  assign pred_ghr   = ghr_q;
  assign init_busy  = (state_q == ST_INIT);
  assign pred_taken = (state_q == ST_RUN) & pred_cnt[CNT_W-1];

  // Two identical copies give the prediction and the update each their own read port.
  pht_ram #(.IDX_W(IDX_W), .CNT_W(CNT_W)) u_pht_pred (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (pred_idx),
    .rdata (pred_cnt)
  );

  pht_ram #(.IDX_W(IDX_W), .CNT_W(CNT_W)) u_pht_upd (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (upd_idx),
    .rdata (upd_cnt)
  );

  // Next-state: sweep in INIT, then counter updates and GHR shift/restore in RUN.
  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    ghr_d      = ghr_q;
    we         = 1'b0;
    waddr      = upd_idx;
    wdata      = CNT_W'(sat_next(4'(upd_cnt), upd_taken, CNT_W));
    unique case (state_q)
      ST_INIT: begin
        we         = 1'b1;
        waddr      = init_ptr_q;
        wdata      = CNT_W'(WEAK_NT(CNT_W));
        init_ptr_d = init_ptr_q + IDX_W'(1);
        if (init_ptr_q == '1) state_d = ST_RUN;
      end
      ST_RUN: begin
        we = upd_valid;
        // A resolved mispredict overrides any speculative shift this cycle.
        if (upd_valid && upd_mispredict) begin
          ghr_d = GHR_W'({upd_ghr, upd_taken});
        end else if (pred_valid && !PL_stall && !PL_flush) begin
          ghr_d = GHR_W'({ghr_q, pred_taken});
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // State, sweep pointer and history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
      ghr_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      ghr_q      <= ghr_d;
    end
  end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed self-checking bench for gshare_predictor (IDX_W=8, GHR_W=8, CNT_W=2).
module tb_gshare_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PL_stall, PL_flush, pred_valid;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic [7:0]  pred_idx, pred_ghr;
  logic        upd_valid, upd_taken, upd_mispredict;
  logic [7:0]  upd_idx, upd_ghr;
  logic        init_busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic        upd_v;
    logic [7:0]  upd_i;
    logic        upd_t;
    logic [7:0]  exp_idx;
    logic        exp_taken;
  } vec_t;

  vec_t vecs[16];

  gshare_predictor #(.IDX_W(8), .GHR_W(8), .CNT_W(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .PL_stall       (PL_stall),
    .PL_flush       (PL_flush),
    .pred_valid     (pred_valid),
    .pred_pc        (pred_pc),
    .pred_taken     (pred_taken),
    .pred_idx       (pred_idx),
    .pred_ghr       (pred_ghr),
    .upd_valid      (upd_valid),
    .upd_idx        (upd_idx),
    .upd_ghr        (upd_ghr),
    .upd_taken      (upd_taken),
    .upd_mispredict (upd_mispredict),
    .init_busy      (init_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are read off-edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_upd();
    upd_valid      = 1'b0;
    upd_idx        = 8'h00;
    upd_ghr        = 8'h00;
    upd_taken      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  // Count sweep cycles while watching that predictions and history stay quiet.
  task automatic sweep(input string tag);
    int  n;
    bit  bad_taken;
    bit  bad_ghr;
    n = 0;
    bad_taken = 0;
    bad_ghr = 0;
    while (init_busy && n < 1000) begin
      if (pred_taken !== 1'b0) bad_taken = 1;
      if (pred_ghr !== 8'h00) bad_ghr = 1;
      step();
      n++;
    end
    check({tag, " sweep cycles"}, n, 256);
    check({tag, " taken during sweep"}, 32'(bad_taken), 0);
    check({tag, " ghr during sweep"}, 32'(bad_ghr), 0);
  endtask

  initial begin
    bit any_taken;

    rst_n = 1'b0;
    PL_stall = 1'b0;
    PL_flush = 1'b0;
    pred_valid = 1'b0;
    pred_pc = 32'h0;
    clear_upd();

    // Training sequence on idx 0x10 (pc 0x40) with a few accesses to idx 0x20 (pc 0x80).
    vecs[0]  = '{32'h40, 1'b1, 8'h10, 1'b1, 8'h10, 1'b0};  // 1->2, old value seen
    vecs[1]  = '{32'h40, 1'b1, 8'h10, 1'b1, 8'h10, 1'b1};  // 2->3
    vecs[2]  = '{32'h80, 1'b1, 8'h10, 1'b1, 8'h20, 1'b0};  // 0x20 untouched at 1
    vecs[3]  = '{32'h40, 1'b1, 8'h10, 1'b1, 8'h10, 1'b1};  // pinned at 3
    vecs[4]  = '{32'h40, 1'b1, 8'h10, 1'b1, 8'h10, 1'b1};
    vecs[5]  = '{32'h40, 1'b1, 8'h10, 1'b0, 8'h10, 1'b1};  // 3->2
    vecs[6]  = '{32'h40, 1'b1, 8'h10, 1'b0, 8'h10, 1'b1};  // 2->1
    vecs[7]  = '{32'h40, 1'b1, 8'h10, 1'b0, 8'h10, 1'b0};  // 1->0
    vecs[8]  = '{32'h40, 1'b1, 8'h10, 1'b0, 8'h10, 1'b0};  // pinned at 0
    vecs[9]  = '{32'h40, 1'b1, 8'h10, 1'b0, 8'h10, 1'b0};
    vecs[10] = '{32'h80, 1'b1, 8'h20, 1'b1, 8'h20, 1'b0};  // 0x20: 1->2
    vecs[11] = '{32'h80, 1'b1, 8'h10, 1'b0, 8'h20, 1'b1};  // 0x20 now 2
    vecs[12] = '{32'h40, 1'b1, 8'h10, 1'b1, 8'h10, 1'b0};  // 0->1, no wrap to 3
    vecs[13] = '{32'h40, 1'b1, 8'h10, 1'b1, 8'h10, 1'b0};  // 1->2
    vecs[14] = '{32'h40, 1'b1, 8'h10, 1'b1, 8'h10, 1'b1};  // 2->3
    vecs[15] = '{32'hFFFF_FC43, 1'b0, 8'h00, 1'b0, 8'h10, 1'b1};  // only pc[9:2] matters

    #2;
    check("reset init_busy", 32'(init_busy), 1);
    check("reset pred_taken", 32'(pred_taken), 0);
    check("reset pred_idx", 32'(pred_idx), 0);
    check("reset pred_ghr", 32'(pred_ghr), 0);
    #10 rst_n = 1'b1;
    sweep("first");
    check("busy after sweep", 32'(init_busy), 0);

    // Every entry should be weak-not-taken.
    any_taken = 0;
    for (int i = 0; i < 256; i++) begin
      pred_pc = 32'(i) << 2;
      #1;
      if (pred_taken !== 1'b0) any_taken = 1;
    end
    check("all entries not-taken after sweep", 32'(any_taken), 0);
    step();

    for (int i = 0; i < 16; i++) begin
      pred_pc   = vecs[i].pc;
      upd_valid = vecs[i].upd_v;
      upd_idx   = vecs[i].upd_i;
      upd_taken = vecs[i].upd_t;
      #2;
      check($sformatf("vec%0d pred_taken", i), 32'(pred_taken), 32'(vecs[i].exp_taken));
      check($sformatf("vec%0d pred_idx", i), 32'(pred_idx), 32'(vecs[i].exp_idx));
      step();
    end
    clear_upd();

    // Stall freezes the history; the release cycle shifts once.
    pred_pc = 32'h40;
    pred_valid = 1'b1;
    PL_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall%0d ghr", i), 32'(pred_ghr), 0);
    end
    PL_stall = 1'b0;
    #2;
    check("release pred_ghr pre-shift", 32'(pred_ghr), 0);
    check("release pred_taken", 32'(pred_taken), 1);
    step();
    pred_valid = 1'b0;
    check("ghr after release shift", 32'(pred_ghr), 32'h01);

    // Flush suppresses the shift.
    pred_valid = 1'b1;
    PL_flush = 1'b1;
    step();
    pred_valid = 1'b0;
    PL_flush = 1'b0;
    check("ghr after flush", 32'(pred_ghr), 32'h01);

    // Mispredict restore: {0x2D[6:0], 0} = 0x5A.
    upd_valid = 1'b1;
    upd_mispredict = 1'b1;
    upd_ghr = 8'h2D;
    upd_taken = 1'b0;
    upd_idx = 8'h30;
    step();
    clear_upd();
    check("ghr after restore", 32'(pred_ghr), 32'h5A);
    pred_pc = 32'h40;
    #1;
    check("idx pc^ghr", 32'(pred_idx), 32'h4A);

    // pc 0x128 -> pc[9:2]=0x4A, xor 0x5A = 0x10 (counter 3).
    pred_pc = 32'h128;
    pred_valid = 1'b1;
    #1;
    check("spec idx", 32'(pred_idx), 32'h10);
    check("spec taken", 32'(pred_taken), 1);
    step();
    pred_valid = 1'b0;
    check("ghr after spec shift", 32'(pred_ghr), 32'hB5);

    // Mispredict wins over a same-cycle speculative shift.
    pred_valid = 1'b1;
    upd_valid = 1'b1;
    upd_mispredict = 1'b1;
    upd_ghr = 8'h12;
    upd_taken = 1'b1;
    upd_idx = 8'h30;
    step();
    pred_valid = 1'b0;
    clear_upd();
    check("ghr restore priority", 32'(pred_ghr), 32'h25);

    // A correctly predicted resolution does not touch the history.
    upd_valid = 1'b1;
    upd_ghr = 8'hFF;
    upd_taken = 1'b1;
    upd_idx = 8'h31;
    step();
    clear_upd();
    check("ghr no restore without mispredict", 32'(pred_ghr), 32'h25);

    // Asynchronous reset mid-run.
    pred_pc = 32'h0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun reset init_busy", 32'(init_busy), 1);
    check("midrun reset pred_taken", 32'(pred_taken), 0);
    check("midrun reset pred_ghr", 32'(pred_ghr), 0);
    check("midrun reset pred_idx", 32'(pred_idx), 0);
    step();
    rst_n = 1'b1;
    // Updates and restores during the sweep must be ignored.
    pred_valid = 1'b1;
    upd_valid = 1'b1;
    upd_mispredict = 1'b1;
    upd_ghr = 8'hFF;
    upd_taken = 1'b1;
    upd_idx = 8'h00;
    sweep("second");
    pred_valid = 1'b0;
    clear_upd();
    #1;
    check("ghr after second sweep", 32'(pred_ghr), 0);
    check("idx0 weak after ignored updates", 32'(pred_taken), 0);
    pred_pc = 32'h40;
    #1;
    check("trained idx 0x10 reinitialised", 32'(pred_taken), 0);
    upd_valid = 1'b1;
    upd_idx = 8'h10;
    upd_taken = 1'b1;
    step();
    clear_upd();
    check("idx 0x10 taken after one update", 32'(pred_taken), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
